// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//
// Shares one combinational ALU among NumReq clients. A single transaction is
// in flight at a time: a client request is granted round-robin, its operands
// and op code are registered onto the ALU inputs, the ALU result and zero flag
// are registered one cycle later, and the response is offered back to the
// client that owns the transaction.
//
// Handshake rule (both request and response channels): a transfer happens on
// a rising clock edge where valid and ready are both 1 for the same client.
// Valid, once raised, is held by its source until that edge. Ready may depend
// combinationally on valid (the request grant does).
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_valid_i[k]      client k has a request
//   req_ready_o[k]      client k's request is accepted this cycle (one-hot/0)
//   req_a_i, req_b_i    operands, client k at [k*Width +: Width]
//   req_op_i            ALU op code, client k at [k*3 +: 3]
//   resp_valid_o[k]     response available for owning client k
//   resp_ready_i[k]     client k consumes the response
//   resp_result_o       registered ALU result (shared by all clients)
//   resp_zero_o         registered ALU zero flag
//   alu_a_o, alu_b_o    ALU operands (registered)
//   alu_control_o       ALU op code (registered)
//   alu_result_i        ALU result, combinational from alu_*_o
//   alu_zero_i          ALU zero flag
//   dbg_state_o         current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module alu_scheduler #(
  parameter int unsigned Width  = 32,
  parameter int unsigned NumReq = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_a_i,
  input  logic [NumReq*Width-1:0] req_b_i,
  input  logic [NumReq*3-1:0]     req_op_i,
  output logic [NumReq-1:0]       resp_valid_o,
  input  logic [NumReq-1:0]       resp_ready_i,
  output logic [Width-1:0]        resp_result_o,
  output logic                    resp_zero_o,
  output logic [Width-1:0]        alu_a_o,
  output logic [Width-1:0]        alu_b_o,
  output logic [2:0]              alu_control_o,
  input  logic [Width-1:0]        alu_result_i,
  input  logic                    alu_zero_i,
  output logic [1:0]              dbg_state_o
);

  localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  // One extra bit so ptr + offset can exceed NumReq before wrapping.
  localparam int unsigned CandW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   own_q, own_d;
  logic [Width-1:0]  alu_a_q, alu_a_d;
  logic [Width-1:0]  alu_b_q, alu_b_d;
  logic [2:0]        alu_ctl_q, alu_ctl_d;
  logic [Width-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  logic              grant_found;
  logic [PtrW-1:0]   grant_idx;
  logic [NumReq-1:0] req_ready_raw;
  logic [NumReq-1:0] resp_valid_raw;

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid client at or after ptr_q, wrapping.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [CandW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + CandW'(i);
      if (cand >= CandW'(NumReq)) begin
        cand = cand - CandW'(NumReq);
      end
      if (!grant_found && req_valid_i[cand[PtrW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PtrW-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    own_d          = own_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctl_d      = alu_ctl_q;
    result_d       = result_q;
    zero_d         = zero_q;
    req_ready_raw  = '0;
    resp_valid_raw = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // Ready is raised only because the winner is valid, so this is
          // also the request handshake.
          req_ready_raw[grant_idx] = 1'b1;
          alu_a_d   = req_a_i[grant_idx*Width +: Width];
          alu_b_d   = req_b_i[grant_idx*Width +: Width];
          alu_ctl_d = req_op_i[grant_idx*3 +: 3];
          own_d     = grant_idx;
          // Pointer moves past the winner only on a handshake, which bounds
          // any waiting client to NumReq transactions.
          if (grant_idx == PtrW'(NumReq - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx + PtrW'(1);
          end
          state_d = EXEC;
        end
      end

      EXEC: begin
        // ALU inputs have been stable for this whole cycle.
        result_d = alu_result_i;
        zero_d   = alu_zero_i;
        state_d  = RESP;
      end

      RESP: begin
        resp_valid_raw[own_q] = 1'b1;
        // Ready from clients other than the owner has no effect.
        if (resp_ready_i[own_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= 3'b000;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  // Reset forces the FSM to IDLE, where the grant is purely combinational;
  // gating with rst_ni keeps ready low for the whole reset interval.
  assign req_ready_o   = req_ready_raw & {NumReq{rst_ni}};
  assign resp_valid_o  = resp_valid_raw;
  assign resp_result_o = result_q;
  assign resp_zero_o   = zero_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_control_o = alu_ctl_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_scheduler
//
// Bench for alu_scheduler with two clients and a behavioural ALU attached to
// the alu_* ports. Expected responses are pushed to exp_q when a request
// handshake is seen and popped when the response appears.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_alu_scheduler;

  localparam int Width  = 32;
  localparam int NumReq = 2;
  localparam int EW     = Width + 3;  // {owner[1:0], zero, result}

  logic                    clk;
  logic                    rst_n;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq*Width-1:0] req_a;
  logic [NumReq*Width-1:0] req_b;
  logic [NumReq*3-1:0]     req_op;
  logic [NumReq-1:0]       resp_valid;
  logic [NumReq-1:0]       resp_ready;
  logic [Width-1:0]        resp_result;
  logic                    resp_zero;
  logic [Width-1:0]        alu_a;
  logic [Width-1:0]        alu_b;
  logic [2:0]              alu_ctl;
  logic [Width-1:0]        alu_result;
  logic                    alu_zero;
  logic [1:0]              dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_scheduler #(.Width(Width), .NumReq(NumReq)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_op_i      (req_op),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_zero_o   (resp_zero),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_control_o (alu_ctl),
    .alu_result_i  (alu_result),
    .alu_zero_i    (alu_zero),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU behavioural model ----------------
  function automatic logic [Width-1:0] alu_fn(input logic [2:0] op,
                                              input logic [Width-1:0] a,
                                              input logic [Width-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? {{(Width-1){1'b0}}, 1'b1} : '0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [EW-1:0] exp_of(input int k, input logic [Width-1:0] a,
                                           input logic [Width-1:0] b, input logic [2:0] op);
    logic [Width-1:0] r;
    r = alu_fn(op, a, b);
    return {2'(k), (r == '0), r};
  endfunction

  function automatic logic [NumReq-1:0] onehot(input int k);
    logic [NumReq-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b110;
      4:       return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic set_client(input int k, input logic [Width-1:0] a,
                            input logic [Width-1:0] b, input logic [2:0] op);
    req_a[k*Width +: Width] = a;
    req_b[k*Width +: Width] = b;
    req_op[k*3 +: 3]        = op;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request grant; cyc = 1 means granted in the cycle
  // the stimulus was applied.
  task automatic wait_grant(output int k, output int cyc);
    k   = -1;
    cyc = 0;
    while (k < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NumReq; i++) begin
        if (req_ready[i] && k < 0) k = i;
      end
    end
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no req_ready within %0d cycles, req_valid=%b", cyc, req_valid);
      finish_run();
    end
  endtask

  // Called right after the request handshake edge. Checks the EXEC cycle,
  // holds the response for `hold` cycles (non-owner ready bits raised as
  // noise), then accepts it and compares with the scoreboard.
  task automatic run_exec_resp(input int k, input logic [Width-1:0] a,
                               input logic [Width-1:0] b, input logic [2:0] op,
                               input int hold);
    logic [EW-1:0]    exp;
    logic [Width-1:0] res0;
    logic             z0;
    res0 = '0;
    z0   = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_a !== a || alu_b !== b || alu_ctl !== op) begin
      errors++;
      $display("FAIL exec_operands: got a=%h b=%h op=%b, want a=%h b=%h op=%b",
               alu_a, alu_b, alu_ctl, a, b, op);
    end
    checks++;
    if (resp_valid !== '0 || req_ready !== '0 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL exec_state: got resp_valid=%b req_ready=%b state=%0d, want 0 0 1",
               resp_valid, req_ready, dbg_state);
    end
    for (int c = 0; c <= hold; c++) begin
      @(posedge clk);
      #1;
      resp_ready = (c == hold) ? onehot(k) : ~onehot(k);
      @(negedge clk);
      checks++;
      if (resp_valid !== onehot(k) || req_ready !== '0) begin
        errors++;
        $display("FAIL resp_valid: cycle %0d got resp_valid=%b req_ready=%b, want %b 0",
                 c, resp_valid, req_ready, onehot(k));
      end
      checks++;
      if (c == 0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: response with no expected entry, result=%h", resp_result);
        end else begin
          exp = exp_q.pop_front();
          if ({2'(k), resp_zero, resp_result} !== exp) begin
            errors++;
            $display("FAIL sb_result: got owner=%0d zero=%b result=%h, want owner=%0d zero=%b result=%h",
                     k, resp_zero, resp_result, exp[EW-1 -: 2], exp[Width], exp[Width-1:0]);
          end
        end
        res0 = resp_result;
        z0   = resp_zero;
      end else begin
        if (resp_result !== res0 || resp_zero !== z0) begin
          errors++;
          $display("FAIL resp_stable: cycle %0d got result=%h zero=%b, want %h %b",
                   c, resp_result, resp_zero, res0, z0);
        end
      end
    end
    @(posedge clk);
    #1;
    resp_ready = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    resp_ready = '0;
    req_valid  = 2'b11;
    set_client(0, 32'h1234_5678, 32'h1, 3'b010);
    set_client(1, 32'hdead_beef, 32'h2, 3'b110);
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL reset_handshake: got req_ready=%b resp_valid=%b, want 0 0", req_ready, resp_valid);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_ctl !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h op=%b, want 0 0 000", alu_a, alu_b, alu_ctl);
    end
    checks++;
    if (resp_result !== '0 || resp_zero !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_resp: got result=%h zero=%b state=%0d, want 0 0 0",
               resp_result, resp_zero, dbg_state);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_add();
    int k, cyc;
    set_client(0, 32'd5, 32'd7, 3'b010);
    req_valid = 2'b01;
    wait_grant(k, cyc);
    checks++;
    if (k != 0 || req_ready !== 2'b01 || cyc != 1) begin
      errors++;
      $display("FAIL single_add_grant: got client=%0d req_ready=%b cycles=%0d, want 0 01 1", k, req_ready, cyc);
    end
    exp_q.push_back({2'd0, 1'b0, 32'd12});
    @(posedge clk);
    #1;
    req_valid = '0;
    run_exec_resp(0, 32'd5, 32'd7, 3'b010, 0);
  endtask

  task automatic test_sub_slt();
    int k, cyc;
    set_client(1, 32'd9, 32'd9, 3'b110);
    req_valid = 2'b10;
    wait_grant(k, cyc);
    checks++;
    if (k != 1 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL sub_grant: got client=%0d req_ready=%b, want 1 10", k, req_ready);
    end
    exp_q.push_back({2'd1, 1'b1, 32'd0});
    @(posedge clk);
    #1;
    set_client(1, 32'd3, 32'd5, 3'b111);
    run_exec_resp(1, 32'd9, 32'd9, 3'b110, 1);
    // Valid stayed high: the next grant must come in the first IDLE cycle.
    wait_grant(k, cyc);
    checks++;
    if (k != 1 || cyc != 1) begin
      errors++;
      $display("FAIL back_to_back: got client=%0d cycles=%0d, want 1 1", k, cyc);
    end
    exp_q.push_back({2'd1, 1'b0, 32'd1});
    @(posedge clk);
    #1;
    req_valid = '0;
    run_exec_resp(1, 32'd3, 32'd5, 3'b111, 0);
  endtask

  task automatic test_undefined_op();
    int k, cyc;
    set_client(0, 32'hFFFF_FFFF, 32'd1, 3'b011);
    req_valid = 2'b01;
    wait_grant(k, cyc);
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL undef_grant: got client=%0d, want 0", k);
    end
    exp_q.push_back({2'd0, 1'b1, 32'd0});
    @(posedge clk);
    #1;
    req_valid = '0;
    run_exec_resp(0, 32'hFFFF_FFFF, 32'd1, 3'b011, 0);
  endtask

  task automatic test_round_robin();
    int k, cyc;
    logic [Width-1:0] sa, sb;
    logic [2:0]       sop;
    do_reset();
    for (int i = 0; i < NumReq; i++) begin
      set_client(i, $urandom, $urandom, rand_op());
    end
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(k, cyc);
      checks++;
      if (k != (t % 2) || req_ready !== onehot(t % 2) || cyc != 1) begin
        errors++;
        $display("FAIL rr_order: txn %0d got client=%0d req_ready=%b cycles=%0d, want %0d %b 1",
                 t, k, req_ready, cyc, t % 2, onehot(t % 2));
      end
      sa  = req_a[k*Width +: Width];
      sb  = req_b[k*Width +: Width];
      sop = req_op[k*3 +: 3];
      exp_q.push_back(exp_of(k, sa, sb, sop));
      @(posedge clk);
      #1;
      set_client(k, $urandom, $urandom, rand_op());
      if (t == 3) req_valid = '0;
      run_exec_resp(k, sa, sb, sop, 0);
    end
  endtask

  task automatic test_backpressure();
    int k, cyc;
    do_reset();
    set_client(0, 32'h0000_00F0, 32'h0000_000F, 3'b001);
    set_client(1, 32'd100, 32'd40, 3'b110);
    req_valid = 2'b11;
    wait_grant(k, cyc);
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL bp_grant0: got client=%0d, want 0", k);
    end
    exp_q.push_back({2'd0, 1'b0, 32'h0000_00FF});
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    run_exec_resp(0, 32'h0000_00F0, 32'h0000_000F, 3'b001, 5);
    wait_grant(k, cyc);
    checks++;
    if (k != 1 || cyc != 1) begin
      errors++;
      $display("FAIL bp_grant1: got client=%0d cycles=%0d, want 1 1", k, cyc);
    end
    exp_q.push_back({2'd1, 1'b0, 32'd60});
    @(posedge clk);
    #1;
    req_valid = '0;
    run_exec_resp(1, 32'd100, 32'd40, 3'b110, 2);
  endtask

  task automatic test_random();
    int k, cyc, win, mptr;
    logic [NumReq-1:0] mask;
    logic [Width-1:0]  ra [NumReq];
    logic [Width-1:0]  rb [NumReq];
    logic [2:0]        rop[NumReq];
    do_reset();
    mptr = 0;
    for (int t = 0; t < 12; t++) begin
      mask = NumReq'($urandom_range(1, (1 << NumReq) - 1));
      for (int i = 0; i < NumReq; i++) begin
        ra[i]  = $urandom;
        rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
        rop[i] = rand_op();
        set_client(i, ra[i], rb[i], rop[i]);
      end
      win = -1;
      for (int i = 0; i < NumReq; i++) begin
        if (win < 0 && mask[(mptr + i) % NumReq]) win = (mptr + i) % NumReq;
      end
      req_valid = mask;
      wait_grant(k, cyc);
      checks++;
      if (k != win || req_ready !== onehot(win)) begin
        errors++;
        $display("FAIL rand_grant: txn %0d mask=%b got client=%0d req_ready=%b, want %0d",
                 t, mask, k, req_ready, win);
      end
      exp_q.push_back(exp_of(win, ra[win], rb[win], rop[win]));
      mptr = (win + 1) % NumReq;
      @(posedge clk);
      #1;
      req_valid = '0;
      run_exec_resp(win, ra[win], rb[win], rop[win], $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_op();
    int k, cyc;
    do_reset();
    set_client(0, 32'hAAAA_0001, 32'h0000_0002, 3'b010);
    set_client(1, 32'd8, 32'd3, 3'b010);
    req_valid = 2'b01;
    wait_grant(k, cyc);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    checks++;
    if (dbg_state !== 2'd1 || alu_a !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL midop_exec: got state=%0d a=%h, want 1 aaaa0001", dbg_state, alu_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_ctl !== 3'b000 || resp_result !== '0 ||
        resp_zero !== 1'b0 || resp_valid !== '0 || req_ready !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midop_reset: got a=%h b=%h op=%b res=%h z=%b rv=%b rr=%b st=%0d, want all 0",
               alu_a, alu_b, alu_ctl, resp_result, resp_zero, resp_valid, req_ready, dbg_state);
    end
    req_valid = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    wait_grant(k, cyc);
    checks++;
    if (k != 0 || cyc != 1) begin
      errors++;
      $display("FAIL midop_ptr: got client=%0d cycles=%0d, want 0 1", k, cyc);
    end
    exp_q.push_back({2'd0, 1'b0, 32'hAAAA_0003});
    @(posedge clk);
    #1;
    req_valid = '0;
    run_exec_resp(0, 32'hAAAA_0001, 32'h0000_0002, 3'b010, 0);
    checks++;
    if (resp_valid !== '0) begin
      errors++;
      $display("FAIL midop_no_stale: got resp_valid=%b after drain, want 0", resp_valid);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    test_reset();
    test_single_add();
    test_sub_slt();
    test_undefined_op();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected responses never seen, want 0", exp_q.size());
    end
    finish_run();
  end

endmodule
